fifo_frame_drain: RTL and testbench

- Downstream consumer of the 512x32 sync FIFO: pops words whenever safe and repackages them as fixed-length frames on a valid/ready stream.
- Frames carry first/last markers and a running frame count.
- Sits between the FIFO's pop/dout/empty interface and the packet sink.
- Pop decision uses registered state only, so no combinational loop through the FIFO's pop-dependent empty.

---
 rtl/fifo_drain_pkg.sv | 18 +
 rtl/fifo_frame_drain_if.sv | 23 ++
 rtl/out_skid_buf.sv | 63 ++++++
 rtl/fifo_frame_drain.sv | 87 ++++++++
 tb/tb_fifo_frame_drain.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_drain_pkg.sv
// Shared types for the FIFO frame drain: FSM states and output-buffer entry.
package fifo_drain_pkg;

  localparam int unsigned DwDefault = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } drain_state_e;

  typedef struct packed {
    logic [DwDefault-1:0] data;
    logic                 first;
    logic                 last;
  } buf_entry_t;

endpackage

// File: rtl/fifo_frame_drain_if.sv
// FIFO read side plus framed valid/ready output stream of the drain block.
interface fifo_frame_drain_if #(
  parameter int unsigned DW = 32
);
  logic          fifo_empty;
  logic [DW-1:0] fifo_dout;
  logic          fifo_pop;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_first;
  logic          m_last;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_pop, m_valid, m_data, m_first, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_pop, m_valid, m_data, m_first, m_last
  );
endinterface

// File: rtl/out_skid_buf.sv
// Two-entry in-order output buffer; head entry drives the stream.
module out_skid_buf
  import fifo_drain_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  buf_entry_t din,
  input  logic       ready,
  output logic       valid,
  output buf_entry_t dout,
  output logic [1:0] occ
);

  buf_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  logic       accept;

  assign valid  = (occ_q != 2'd0);
  assign accept = valid & ready;
  assign dout   = head_q;
  assign occ    = occ_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    case ({push, accept})
      2'b11: begin
        // Occupancy unchanged; the new word goes behind whatever remains.
        if (occ_q == 2'd2) begin
          head_d = tail_q;
          tail_d = din;
        end else begin
          head_d = din;
        end
      end
      2'b01: begin
        head_d = tail_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b10: begin
        if (occ_q == 2'd0) head_d = din;
        else               tail_d = din;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= 2'd0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_frame_drain.sv
// Drains a sync FIFO into fixed-length frames with first/last tags and a frame count.
module fifo_frame_drain
  import fifo_drain_pkg::*;
#(
  parameter int unsigned DW        = DwDefault,
  parameter int unsigned FRAME_LEN = 4,
  parameter int unsigned FCW       = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  fifo_frame_drain_if.master  bus,
  output logic [FCW-1:0]      frame_cnt,
  output logic                busy
);

  localparam int unsigned IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(FRAME_LEN - 1);

  drain_state_e   state_q, state_d;
  logic           empty_q;
  logic [IW-1:0]  idx_q, idx_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic           pop;
  logic [1:0]     occ;
  logic           buf_valid;
  buf_entry_t     push_ent, head;

  // Only registered terms here: fifo_empty itself depends on fifo_pop.
  assign pop = (state_q != IDLE) & ~empty_q & (occ != 2'd2) &
               ~((state_q == DRAIN) & (idx_q == '0));

  assign idx_d = !pop ? idx_q : ((idx_q == LastIdx) ? '0 : idx_q + 1'b1);

  assign push_ent = '{data: DwDefault'(bus.fifo_dout), first: (idx_q == '0),
                      last: (idx_q == LastIdx)};

  out_skid_buf u_out_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (pop),
    .din   (push_ent),
    .ready (bus.m_ready),
    .valid (buf_valid),
    .dout  (head),
    .occ   (occ)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (en) state_d = RUN;
      RUN:   if (!en) state_d = (idx_d == '0) ? IDLE : DRAIN;
      DRAIN: begin
        if (en)                 state_d = RUN;
        else if (idx_d == '0)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign frame_cnt_d = frame_cnt_q +
                       FCW'(buf_valid & bus.m_ready & head.last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      empty_q     <= 1'b1;
      idx_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      empty_q     <= bus.fifo_empty;
      idx_q       <= idx_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.fifo_pop = pop;
  assign bus.m_valid  = buf_valid;
  assign bus.m_data   = DW'(head.data);
  assign bus.m_first  = head.first;
  assign bus.m_last   = head.last;
  assign frame_cnt    = frame_cnt_q;
  assign busy         = (state_q != IDLE) | (occ != 2'd0);

endmodule

// File: tb/tb_fifo_frame_drain.sv
// Bench for fifo_frame_drain with a behavioural FIFO on the read side.
module tb_fifo_frame_drain;

  typedef struct {
    logic [31:0] din;
    logic        first;
    logic        last;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [15:0] frame_cnt;
  logic        busy;

  fifo_frame_drain_if #(.DW(32)) bus ();

  fifo_frame_drain #(
    .DW        (32),
    .FRAME_LEN (4),
    .FCW       (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .bus       (bus),
    .frame_cnt (frame_cnt),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural FIFO: empty is combinational and already 1 while the last word pops.
  logic [31:0] mem [0:31];
  int          rd_ptr, wr_ptr, fcount;
  logic        push_en = 1'b0;
  logic [31:0] push_data = '0;
  logic        fake_nonempty = 1'b0;

  assign fcount         = wr_ptr - rd_ptr;
  assign bus.fifo_empty = fake_nonempty ? 1'b0 :
                          ((fcount == 0) || (fcount == 1 && bus.fifo_pop));
  assign bus.fifo_dout  = mem[rd_ptr[4:0]];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= 0;
      wr_ptr <= 0;
    end else begin
      if (bus.fifo_pop) rd_ptr <= rd_ptr + 1;
      if (push_en) begin
        mem[wr_ptr[4:0]] <= push_data;
        wr_ptr <= wr_ptr + 1;
      end
    end
  end

  // Monitor: pops and accepted output words.
  int          pop_count, empty_pops, out_n;
  logic [31:0] out_data  [0:15];
  logic        out_first [0:15];
  logic        out_last  [0:15];
  logic        clr_log = 1'b0;

  always @(posedge clk) begin
    if (clr_log) begin
      pop_count  <= 0;
      empty_pops <= 0;
      out_n      <= 0;
    end else begin
      if (bus.fifo_pop) begin
        pop_count <= pop_count + 1;
        if (fcount == 0) empty_pops <= empty_pops + 1;
      end
      if (bus.m_valid && bus.m_ready && out_n < 16) begin
        out_data[out_n]  <= bus.m_data;
        out_first[out_n] <= bus.m_first;
        out_last[out_n]  <= bus.m_last;
        out_n            <= out_n + 1;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    clr_log = 1'b1;
    @(negedge clk);
    clr_log = 1'b0;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      push_en   = 1'b1;
      push_data = base + 32'(i);
      @(negedge clk);
    end
    push_en = 1'b0;
  endtask

  task automatic reset_dut();
    en          = 1'b0;
    bus.m_ready = 1'b1;
    rst         = 1'b0;
    clear_log();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  vec_t st_vec [8];
  vec_t bp_vec [4];

  initial begin
    st_vec[0] = '{32'h10, 1'b1, 1'b0};
    st_vec[1] = '{32'h11, 1'b0, 1'b0};
    st_vec[2] = '{32'h12, 1'b0, 1'b0};
    st_vec[3] = '{32'h13, 1'b0, 1'b1};
    st_vec[4] = '{32'h14, 1'b1, 1'b0};
    st_vec[5] = '{32'h15, 1'b0, 1'b0};
    st_vec[6] = '{32'h16, 1'b0, 1'b0};
    st_vec[7] = '{32'h17, 1'b0, 1'b1};
    bp_vec[0] = '{32'hA0, 1'b1, 1'b0};
    bp_vec[1] = '{32'hA1, 1'b0, 1'b0};
    bp_vec[2] = '{32'hA2, 1'b0, 1'b0};
    bp_vec[3] = '{32'hA3, 1'b0, 1'b1};

    bus.m_ready = 1'b1;

    // Reset held with en=1 and a non-empty FIFO
    rst           = 1'b0;
    en            = 1'b1;
    fake_nonempty = 1'b1;
    clr_log       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_pop", {31'b0, bus.fifo_pop}, 32'd0);
      check("rst_valid", {31'b0, bus.m_valid}, 32'd0);
      check("rst_fcnt", {16'b0, frame_cnt}, 32'd0);
    end
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_data", bus.m_data, 32'd0);
    clr_log       = 1'b0;
    fake_nonempty = 1'b0;
    en            = 1'b0;
    rst           = 1'b1;
    @(negedge clk);

    // Streaming two frames
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      push_en   = 1'b1;
      push_data = st_vec[i].din;
      @(negedge clk);
    end
    push_en = 1'b0;
    repeat (2) @(negedge clk);
    clear_log();
    en = 1'b1;
    check("st_pop_same_cycle", {31'b0, bus.fifo_pop}, 32'd0);
    @(negedge clk);
    check("st_pop_first", {31'b0, bus.fifo_pop}, 32'd1);
    repeat (15) @(negedge clk);
    check("st_count", out_n, 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("st_data%0d", i), out_data[i], st_vec[i].din);
      check($sformatf("st_first%0d", i), {31'b0, out_first[i]}, {31'b0, st_vec[i].first});
      check($sformatf("st_last%0d", i), {31'b0, out_last[i]}, {31'b0, st_vec[i].last});
    end
    check("st_fcnt", {16'b0, frame_cnt}, 32'd2);
    check("st_pops", pop_count, 32'd8);
    check("st_empty_pops", empty_pops, 32'd0);
    en = 1'b0;

    // Backpressure
    reset_dut();
    push_words(32'hA0, 4);
    repeat (2) @(negedge clk);
    clear_log();
    bus.m_ready = 1'b0;
    en          = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k >= 2) check($sformatf("bp_hold%0d", k), bus.m_data, 32'hA0);
    end
    check("bp_pops", pop_count, 32'd2);
    check("bp_valid", {31'b0, bus.m_valid}, 32'd1);
    check("bp_first", {31'b0, bus.m_first}, 32'd1);
    bus.m_ready = 1'b1;
    repeat (8) @(negedge clk);
    check("bp_count", out_n, 32'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp_data%0d", i), out_data[i], bp_vec[i].din);
      check($sformatf("bp_last%0d", i), {31'b0, out_last[i]}, {31'b0, bp_vec[i].last});
    end
    check("bp_fcnt", {16'b0, frame_cnt}, 32'd1);
    en = 1'b0;

    // Disable mid-frame: the frame completes, nothing beyond it is popped
    reset_dut();
    push_words(32'hB0, 6);
    repeat (2) @(negedge clk);
    clear_log();
    en = 1'b1;
    for (int k = 0; k < 10 && pop_count != 2; k++) @(negedge clk);
    check("dis_two_pops", pop_count, 32'd2);
    en = 1'b0;
    for (int k = 0; k < 10 && !(bus.m_valid && bus.m_last); k++) @(negedge clk);
    check("dis_last_seen", {31'b0, bus.m_valid & bus.m_last}, 32'd1);
    check("dis_busy_before", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("dis_busy_after", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    check("dis_pops", pop_count, 32'd4);
    check("dis_fifo_left", fcount, 32'd2);
    check("dis_fcnt", {16'b0, frame_cnt}, 32'd1);
    check("dis_no_pop", {31'b0, bus.fifo_pop}, 32'd0);

    // Single word into an empty FIFO
    reset_dut();
    en = 1'b1;
    repeat (3) @(negedge clk);
    push_en   = 1'b1;
    push_data = 32'h55;
    @(negedge clk);
    push_en = 1'b0;
    check("em_pop_early", {31'b0, bus.fifo_pop}, 32'd0);
    @(negedge clk);
    check("em_pop", {31'b0, bus.fifo_pop}, 32'd1);
    check("em_empty_during_pop", {31'b0, bus.fifo_empty}, 32'd1);
    @(negedge clk);
    check("em_valid", {31'b0, bus.m_valid}, 32'd1);
    check("em_data", bus.m_data, 32'h55);
    check("em_first", {31'b0, bus.m_first}, 32'd1);
    check("em_last", {31'b0, bus.m_last}, 32'd0);
    check("em_no_pop", {31'b0, bus.fifo_pop}, 32'd0);
    repeat (4) @(negedge clk);
    check("em_pops", pop_count, 32'd1);
    en = 1'b0;

    // Asynchronous reset with two buffered words
    reset_dut();
    push_words(32'hC0, 4);
    repeat (2) @(negedge clk);
    bus.m_ready = 1'b0;
    en          = 1'b1;
    repeat (5) @(negedge clk);
    check("ar_valid_pre", {31'b0, bus.m_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid_drop", {31'b0, bus.m_valid}, 32'd0);
    check("ar_data_clr", bus.m_data, 32'd0);
    check("ar_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    rst         = 1'b1;
    bus.m_ready = 1'b1;
    clear_log();
    push_words(32'hD0, 2);
    repeat (6) @(negedge clk);
    check("ar_count", out_n, 32'd2);
    check("ar_data0", out_data[0], 32'hD0);
    check("ar_first0", {31'b0, out_first[0]}, 32'd1);
    check("ar_first1", {31'b0, out_first[1]}, 32'd0);
    check("ar_last1", {31'b0, out_last[1]}, 32'd0);
    en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
